mac_operand_fifo: RTL and testbench
===================================

# mac_operand_fifo

Parametrised operand staging buffer for the MAC peripheral. It is the successor to the fixed single-stage 8-bit input register: it adds configurable operand width, a DEPTH-entry circular buffer, valid/ready handshaking on both sides, and an occupancy count. It sits between the host-facing input decode and the multiplier/accumulator datapath. Each entry carries one operand pair plus its clear and signed-mode qualifiers, so the datapath can stall without dropping operands.

## Interface
Parameters:
- DATA_W, 8, operand width in bits (≥ 2)
- DEPTH, 4, number of buffer entries (power of two, ≥ 2)

Ports:
- clk  input  1  single clock; all state updates on its rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  upstream presents an entry
- in_ready  output  1  buffer can accept an entry this cycle
- in_a  input  DATA_W  operand A
- in_b  input  DATA_W  operand B
- in_clear  input  1  clear-accumulator qualifier travelling with the pair
- in_signed  input  1  signed-mode qualifier travelling with the pair
- out_valid  output  1  head entry available
- out_ready  input  1  datapath consumes head entry
- out_a, out_b  output  DATA_W  head operands
- out_clear, out_signed  output  1  head qualifiers
- level  output  $clog2(DEPTH)+1  current entry count, 0..DEPTH
- flush  input  1  present only with MAC_IN_FLUSH_EN

## Operation
- Storage: DEPTH entries of {a, b, clear, signed}, addressed by write pointer wr_ptr and read pointer rd_ptr. Each pointer is $clog2(DEPTH) bits wide and wraps DEPTH-1 → 0.
- Push occurs when in_valid && in_ready. The entry is written at wr_ptr, and wr_ptr increments.
- Pop occurs when out_valid && out_ready. rd_ptr increments.
- in_ready = (level != DEPTH).
- out_valid = (level != 0).
- Both in_ready and out_valid decode registered level only. There is no combinational path from out_ready to in_ready, or from in_valid to out_valid.
- out_a, out_b, out_clear and out_signed show the entry at rd_ptr while out_valid = 1. They are forced to 0 while out_valid = 0.
- level update per cycle: +1 on push only, −1 on pop only, unchanged on both or neither.
- Simultaneous push and pop with 0 < level < DEPTH: both pointers advance and level is unchanged.
- Full: in_ready = 0. Upstream must hold in_a, in_b, in_clear and in_signed stable while in_valid = 1. A pop while full deasserts nothing in that cycle; in_ready returns the following cycle.
- Empty: an out_ready pulse has no effect.
- Data integrity: entries are not reordered, dropped or duplicated. The qualifiers stay bound to their operand pair.
- No arithmetic is performed on the operands. in_signed is carried through unchanged, and the multiplier interprets it.

## Timing
- Reset values (rst high at a rising edge):
  - wr_ptr = rd_ptr = 0, level = 0
  - in_ready = 1, out_valid = 0
  - out_a, out_b, out_clear, out_signed = 0
- Storage array contents are not reset.
- Reset mid-operation discards all held entries. The first edge with rst low behaves as from an empty buffer.
- Fall-through latency: an entry pushed at edge N is visible on the outputs with out_valid = 1 after edge N, so it can be consumed at edge N+1.
- Throughput: one push and one pop per cycle, sustained.

## Configuration
- MAC_IN_FLUSH_EN defined:
  - The flush port exists.
  - flush = 1 at an edge sets rd_ptr = wr_ptr = 0 and level = 0. Any push in that same cycle is discarded.
  - out_valid = 0 and in_ready = 1 from the next cycle.
  - rst has priority over flush.
- MAC_IN_FLUSH_EN undefined:
  - The flush port is absent, and entries leave only by pop or rst.

## Structure
- Shared package mac_pkg holds:
  - MAC_DATA_W_DEFAULT = 8
  - MAC_IN_DEPTH_DEFAULT = 4
  - typedef mac_operand_t, a packed struct {a, b, clear, signed_mode}, parametrised by width through the package constant
- One sub-module is natural: mac_fifo_ctrl, which owns the pointers, level, in_ready and out_valid. The top level holds the storage array and the output zero-mux.

## Test plan
- Reset then single entry: push a=0x12, b=0x34, clear=0, signed=1 → after one edge out_valid = 1, out_a = 0x12, out_b = 0x34, out_signed = 1, level = 1. Pop → level = 0, all outputs 0.
- Fill to full (DEPTH = 4) with out_ready = 0, a = 1..4 → in_ready = 0 at level 4. A fifth in_valid is not accepted. Drain returns a = 1, 2, 3, 4 in order.
- Simultaneous push and pop at level = 2 for 10 cycles with incrementing a → level stays 2, outputs strictly in order. Pointer wrap is exercised.
- Full buffer, pop and push offered in the same cycle → pop happens, push is refused (in_ready = 0). The next cycle shows level = 3 and in_ready = 1.
- rst asserted at level = 3 → next cycle level = 0, out_valid = 0, out_a = 0. A new push of a = 0xAA appears as the head entry.
- With MAC_IN_FLUSH_EN: level = 2, flush with in_valid = 1, a = 0x55 → level = 0, out_valid = 0, and 0x55 never appears at the output.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared MAC definitions: default operand width, operand-buffer depth and the
// operand-pair entry type.
package mac_pkg;

   localparam int MAC_DATA_W_DEFAULT   = 8;
   localparam int MAC_IN_DEPTH_DEFAULT = 4;

   typedef struct packed {
      logic [MAC_DATA_W_DEFAULT-1:0] a;
      logic [MAC_DATA_W_DEFAULT-1:0] b;
      logic                          clear;
      logic                          signed_mode;
   } mac_operand_t;

endpackage

// File: rtl/mac_operand_fifo_if.sv
// Handshake bundle for the MAC operand buffer: upstream push side, datapath pop
// side and the occupancy count. The buffer itself uses the slave modport.
interface mac_operand_fifo_if
   import mac_pkg::*;
#(
   parameter int DATA_W = MAC_DATA_W_DEFAULT,
   parameter int DEPTH  = MAC_IN_DEPTH_DEFAULT
);

   logic                     in_valid;
   logic                     in_ready;
   logic [DATA_W-1:0]        in_a;
   logic [DATA_W-1:0]        in_b;
   logic                     in_clear;
   logic                     in_signed;

   logic                     out_valid;
   logic                     out_ready;
   logic [DATA_W-1:0]        out_a;
   logic [DATA_W-1:0]        out_b;
   logic                     out_clear;
   logic                     out_signed;

   logic [$clog2(DEPTH):0]   level;

   modport master (
      output in_valid, in_a, in_b, in_clear, in_signed, out_ready,
      input  in_ready, out_valid, out_a, out_b, out_clear, out_signed, level
   );

   modport slave (
      input  in_valid, in_a, in_b, in_clear, in_signed, out_ready,
      output in_ready, out_valid, out_a, out_b, out_clear, out_signed, level
   );

endinterface

// File: rtl/mac_fifo_ctrl.sv
// Pointer/occupancy controller for the operand buffer. in_ready and out_valid
// are registered so neither depends combinationally on the opposite handshake.
module mac_fifo_ctrl #(
   parameter int  DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int LW    = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          in_valid,
   input  logic          out_ready,
   output logic          in_ready,
   output logic          out_valid,
   output logic          wr_en,
   output logic [AW-1:0] wr_ptr,
   output logic [AW-1:0] rd_ptr,
   output logic [LW-1:0] level
);

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          in_ready_q, in_ready_d;
   logic          out_valid_q, out_valid_d;
   logic          push, pop;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      push        = in_valid && in_ready_q;
      pop         = out_valid_q && out_ready;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      level_d     = level_q;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
      // Flush empties the buffer and drops any push offered in the same cycle.
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end
      in_ready_d  = (level_d != LW'(DEPTH));
      out_valid_d = (level_d != '0);
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign wr_en     = push && !flush;
   assign wr_ptr    = wr_ptr_q;
   assign rd_ptr    = rd_ptr_q;
   assign level     = level_q;
   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;

endmodule

// File: rtl/mac_operand_fifo.sv
// Operand staging buffer between input decode and the MAC datapath.
// Optional synchronous flush port enabled by defining MAC_IN_FLUSH_EN.
module mac_operand_fifo
   import mac_pkg::*;
#(
   parameter int DATA_W = MAC_DATA_W_DEFAULT,
   parameter int DEPTH  = MAC_IN_DEPTH_DEFAULT
) (
   input  logic               clk,
   input  logic               rst,
`ifdef MAC_IN_FLUSH_EN
   input  logic               flush,
`endif
   mac_operand_fifo_if.slave  bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef struct packed {
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic              clear;
      logic              signed_mode;
   } entry_t;

   logic          flush_w;
   logic          wr_en;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [LW-1:0] level;
   logic          in_ready, out_valid;
   entry_t        wr_entry, head;
   entry_t        mem_q [DEPTH];

`ifdef MAC_IN_FLUSH_EN
   assign flush_w = flush;
`else
   assign flush_w = 1'b0;
`endif

   mac_fifo_ctrl #(.DEPTH(DEPTH)) u_ctrl (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush_w),
      .in_valid  (bus.in_valid),
      .out_ready (bus.out_ready),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .wr_en     (wr_en),
      .wr_ptr    (wr_ptr),
      .rd_ptr    (rd_ptr),
      .level     (level)
   );

   assign wr_entry = '{a: bus.in_a, b: bus.in_b, clear: bus.in_clear, signed_mode: bus.in_signed};

   // NOTE: the storage array is deliberately not reset; an empty buffer never exposes it.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr] <= wr_entry;
   end

   // Head entry is zero-forced whenever nothing valid is held.
   assign head = out_valid ? mem_q[rd_ptr] : '0;

   assign bus.in_ready   = in_ready;
   assign bus.out_valid  = out_valid;
   assign bus.level      = level;
   assign bus.out_a      = head.a;
   assign bus.out_b      = head.b;
   assign bus.out_clear  = head.clear;
   assign bus.out_signed = head.signed_mode;

endmodule

// File: tb/tb_mac_operand_fifo.sv
// Self-checking bench for mac_operand_fifo: queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_mac_operand_fifo;
   import mac_pkg::*;

   localparam int DW = 8;
   localparam int DP = 4;

   logic clk = 1'b0;
   logic rst;
   logic flush;
   int   total = 0;
   int   bad   = 0;
   bit   started = 1'b0;

   mac_operand_t mq [$];

   mac_operand_fifo_if #(.DATA_W(DW), .DEPTH(DP)) bus ();

   mac_operand_fifo #(.DATA_W(DW), .DEPTH(DP)) dut (
      .clk   (clk),
      .rst   (rst),
`ifdef MAC_IN_FLUSH_EN
      .flush (flush),
`endif
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: a bounded queue updated from the inputs seen at each edge.
   always @(posedge clk) begin
      bit do_pop, do_push;
      mac_operand_t e;
      started <= 1'b1;
      if (rst === 1'b1 || flush === 1'b1) begin
         mq.delete();
      end else begin
         do_pop  = (mq.size() != 0) && bus.out_ready;
         do_push = bus.in_valid && (mq.size() != DP);
         e.a = bus.in_a; e.b = bus.in_b; e.clear = bus.in_clear; e.signed_mode = bus.in_signed;
         if (do_pop)  void'(mq.pop_front());
         if (do_push) mq.push_back(e);
      end
   end

   always @(negedge clk) begin
      if (started) begin
         check("cmp_level",     32'(bus.level),     32'(mq.size()));
         check("cmp_in_ready",  32'(bus.in_ready),  32'(mq.size() != DP));
         check("cmp_out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
         check("cmp_out_a",     32'(bus.out_a),     mq.size() != 0 ? 32'(mq[0].a) : 32'd0);
         check("cmp_out_b",     32'(bus.out_b),     mq.size() != 0 ? 32'(mq[0].b) : 32'd0);
         check("cmp_out_clear", 32'(bus.out_clear), mq.size() != 0 ? 32'(mq[0].clear) : 32'd0);
         check("cmp_out_sign",  32'(bus.out_signed),mq.size() != 0 ? 32'(mq[0].signed_mode) : 32'd0);
      end
   end

   // One clock of stimulus; returns just after the following falling edge.
   task automatic cyc(input logic v, input logic [7:0] a, input logic [7:0] b,
                      input logic c, input logic s, input logic r);
      bus.in_valid  = v;
      bus.in_a      = a;
      bus.in_b      = b;
      bus.in_clear  = c;
      bus.in_signed = s;
      bus.out_ready = r;
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic idle(input logic r);
      cyc(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, r);
   endtask

   initial begin
      rst   = 1'b1;
      flush = 1'b0;
      idle(1'b0);
      idle(1'b0);
      rst = 1'b0;
      check("rst_level",     32'(bus.level), 0);
      check("rst_in_ready",  32'(bus.in_ready), 1);
      check("rst_out_valid", 32'(bus.out_valid), 0);
      check("rst_out_a",     32'(bus.out_a), 0);

      // Single entry: fall-through after one edge, then pop.
      cyc(1'b1, 8'h12, 8'h34, 1'b0, 1'b1, 1'b0);
      check("s1_valid",  32'(bus.out_valid), 1);
      check("s1_a",      32'(bus.out_a), 32'h12);
      check("s1_b",      32'(bus.out_b), 32'h34);
      check("s1_signed", 32'(bus.out_signed), 1);
      check("s1_clear",  32'(bus.out_clear), 0);
      check("s1_level",  32'(bus.level), 1);
      idle(1'b1);
      check("s1_pop_level", 32'(bus.level), 0);
      check("s1_pop_a",     32'(bus.out_a), 0);
      check("s1_pop_sign",  32'(bus.out_signed), 0);

      // Fill to full, offer a fifth entry, then drain in order.
      for (int i = 1; i <= 4; i++)
         cyc(1'b1, 8'(i), 8'(i + 16), i[0], i[1], 1'b0);
      check("full_in_ready", 32'(bus.in_ready), 0);
      check("full_level",    32'(bus.level), 4);
      cyc(1'b1, 8'h05, 8'h15, 1'b1, 1'b0, 1'b0);
      check("full_5th_level", 32'(bus.level), 4);
      check("full_head",      32'(bus.out_a), 1);
      for (int i = 1; i <= 4; i++) begin
         check("drain_a", 32'(bus.out_a), 32'(i));
         check("drain_b", 32'(bus.out_b), 32'(i + 16));
         idle(1'b1);
      end
      check("drain_level", 32'(bus.level), 0);

      // Sustained push+pop at level 2, pointers wrap several times.
      cyc(1'b1, 8'h20, 8'hA0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 8'h21, 8'hA1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         check("strm_head", 32'(bus.out_a), 32'(8'h20 + i));
         cyc(1'b1, 8'(8'h22 + i), 8'(8'hA2 + i), i[0], i[1], 1'b1);
         check("strm_level", 32'(bus.level), 2);
      end
      check("strm_head_end", 32'(bus.out_a), 32'h2A);

      // Fill, then pop and push together while full: push refused.
      cyc(1'b1, 8'h2C, 8'hAC, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 8'h2D, 8'hAD, 1'b0, 1'b0, 1'b0);
      check("fp_full", 32'(bus.in_ready), 0);
      cyc(1'b1, 8'h77, 8'h88, 1'b1, 1'b1, 1'b1);
      check("fp_level",    32'(bus.level), 3);
      check("fp_in_ready", 32'(bus.in_ready), 1);
      check("fp_head",     32'(bus.out_a), 32'h2B);
      cyc(1'b1, 8'h77, 8'h88, 1'b1, 1'b1, 1'b0);
      check("fp_accept", 32'(bus.level), 4);
      idle(1'b1);
      check("pre_rst_level", 32'(bus.level), 3);

      // Reset mid-operation discards held entries.
      rst = 1'b1;
      idle(1'b0);
      rst = 1'b0;
      check("mrst_level", 32'(bus.level), 0);
      check("mrst_valid", 32'(bus.out_valid), 0);
      check("mrst_a",     32'(bus.out_a), 0);
      cyc(1'b1, 8'hAA, 8'hBB, 1'b1, 1'b0, 1'b0);
      check("mrst_head",  32'(bus.out_a), 32'hAA);
      check("mrst_clear", 32'(bus.out_clear), 1);

`ifdef MAC_IN_FLUSH_EN
      // Flush at level 2 with a push offered: everything dropped.
      cyc(1'b1, 8'hAB, 8'hBC, 1'b0, 1'b0, 1'b0);
      check("fl_pre_level", 32'(bus.level), 2);
      flush = 1'b1;
      cyc(1'b1, 8'h55, 8'h66, 1'b0, 1'b1, 1'b0);
      flush = 1'b0;
      check("fl_level",    32'(bus.level), 0);
      check("fl_valid",    32'(bus.out_valid), 0);
      check("fl_in_ready", 32'(bus.in_ready), 1);
      for (int i = 0; i < 3; i++) begin
         idle(1'b1);
         check("fl_no55", 32'(bus.out_valid), 0);
      end
`endif

      idle(1'b1);
      idle(1'b1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
